branch_resolve_unit: RTL

Commit-side partner of the fetch-stage branch predictor. It accepts one committed control-flow instruction per cycle from the ROB and decides whether it was mispredicted. It drives the predictor update port (ena/hit/pc) and, on a mispredict, the pipeline rollback with the correct fetch PC. It also holds a flush-window state machine and saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_unit_pkg.sv | 38 +++
 rtl/branch_resolve_unit_sat_counter.sv | 20 ++
 rtl/branch_resolve_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared commit-side definitions: opcode encodings, address/data types and
// the control-flow classification helper used by the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int OPCODE_W = 7;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam opcode_t OPCODE_BR   = 7'b1100011;
  localparam opcode_t OPCODE_JAL  = 7'b1101111;
  localparam opcode_t OPCODE_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_BR   = 2'd1,
    CF_JAL  = 2'd2,
    CF_JALR = 2'd3
  } cf_kind_t;

  function automatic cf_kind_t classify(input opcode_t opcode);
    cf_kind_t kind;
    case (opcode)
      OPCODE_BR:   kind = CF_BR;
      OPCODE_JAL:  kind = CF_JAL;
      OPCODE_JALR: kind = CF_JALR;
      default:     kind = CF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping so long-running statistics never read as small values.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Commit-side branch resolution: predictor update, mispredict rollback,
// flush-window backpressure and saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [OPCODE_W-1:0]  commit_opcode,
  input  logic [ADDR_W-1:0]    commit_pc,
  input  logic                 commit_pred_jump,
  input  logic                 commit_actual_jump,
  input  logic [ADDR_W-1:0]    commit_next_pc,
  output logic                 ena_to_pred,
  output logic                 hit_to_pred,
  output logic [ADDR_W-1:0]    pc_to_pred,
  output logic                 rollback,
  output logic [ADDR_W-1:0]    rollback_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;
  cf_kind_t   kind;
  logic       accept;
  logic       br_accept;
  logic       mispredict;

  always_comb begin
    kind       = classify(commit_opcode);
    accept     = commit_valid & commit_ready;
    br_accept  = accept & (kind == CF_BR);
    // JAL is always predicted taken and JALR always not taken, so the
    // prediction inputs only matter for conditional branches.
    mispredict = accept & (((kind == CF_BR) & (commit_pred_jump != commit_actual_jump))
                           | (kind == CF_JALR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      commit_ready <= TRUE;
      ena_to_pred  <= FALSE;
      hit_to_pred  <= FALSE;
      pc_to_pred   <= '0;
      rollback     <= FALSE;
      rollback_pc  <= '0;
    end else begin
      ena_to_pred <= br_accept;
      hit_to_pred <= br_accept & commit_actual_jump;
      pc_to_pred  <= br_accept ? commit_pc : '0;
      rollback    <= mispredict;
      rollback_pc <= mispredict ? commit_next_pc : '0;

      if (state == IDLE) begin
        if (mispredict) begin
          state        <= FLUSH;
          flush_cnt    <= FLUSH_LOAD;
          commit_ready <= FALSE;
        end
      end else begin
        // The cycle carrying the rollback pulse is already the first flush cycle.
        if (flush_cnt <= 4'd1) begin
          state        <= IDLE;
          flush_cnt    <= '0;
          commit_ready <= TRUE;
        end else begin
          flush_cnt <= flush_cnt - 4'd1;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .inc   (br_accept),
    .clr   (rst),
    .value (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .inc   (mispredict),
    .clr   (rst),
    .value (miss_cnt)
  );

endmodule
